// File: rtl/servo_ramp.sv
// Rate-limited position sequencer feeding the servo PWM compare register.
// Optional autonomous sweep mode is built only when SERVO_RAMP_SWEEP_EN is defined.
module servo_ramp #(
    parameter logic [15:0] PMIN    = 16'h0600,
    parameter logic [15:0] PMAX    = 16'h1A00,
    parameter logic [15:0] STEP    = 16'h0010,
    parameter logic [15:0] TICKDIV = 16'd49999
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    input  logic [15:0] tgt_data,
    input  logic [15:0] tgt_step,
    input  logic        sweep,
    output logic [15:0] setPwm,
    output logic        busy,
    output logic        done
);

`ifdef SERVO_RAMP_SWEEP_EN
    typedef enum logic [1:0] {IDLE, RAMP, SWEEP_UP, SWEEP_DN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RAMP} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pwm_q, pwm_d;
    logic [15:0] tgt_q, tgt_d;
    logic [15:0] step_q, step_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick;
    logic        accept;
    logic [16:0] diff;

    function automatic logic [15:0] clamp(input logic [15:0] v);
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    assign tick   = (cnt_q == TICKDIV);
    assign cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
    assign accept = tgt_valid && ready_q;
    // Both operands are within 16 bits, so the 17-bit magnitude cannot wrap.
    assign diff   = (tgt_q >= pwm_q) ? ({1'b0, tgt_q} - {1'b0, pwm_q})
                                     : ({1'b0, pwm_q} - {1'b0, tgt_q});

`ifdef SERVO_RAMP_SWEEP_EN
    logic [16:0] up_sum;
    assign up_sum = {1'b0, pwm_q} + {1'b0, STEP};
`else
    logic unused_sweep;
    assign unused_sweep = ^{sweep, STEP};
`endif

    always_comb begin
        state_d = state_q;
        pwm_d   = pwm_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        done_d  = 1'b0;
        if (accept) begin
            // A tick landing on the accept edge is deliberately dropped.
            tgt_d   = clamp(tgt_data);
            step_d  = (tgt_step == 16'd0) ? 16'd1 : tgt_step;
            state_d = RAMP;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef SERVO_RAMP_SWEEP_EN
                    if (sweep) state_d = SWEEP_UP;
`endif
                end
                RAMP: begin
                    if (tick) begin
                        if (diff <= {1'b0, step_q}) begin
                            pwm_d   = tgt_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else if (tgt_q > pwm_q) begin
                            pwm_d = pwm_q + step_q;
                        end else begin
                            pwm_d = pwm_q - step_q;
                        end
                    end
                end
`ifdef SERVO_RAMP_SWEEP_EN
                SWEEP_UP: begin
                    if (tick) begin
                        if (!sweep) begin
                            state_d = IDLE;
                        end else if (up_sum >= {1'b0, PMAX}) begin
                            pwm_d   = PMAX;
                            state_d = SWEEP_DN;
                        end else begin
                            pwm_d = up_sum[15:0];
                        end
                    end
                end
                SWEEP_DN: begin
                    if (tick) begin
                        if (!sweep) begin
                            state_d = IDLE;
                        end else if ({1'b0, pwm_q} <= ({1'b0, PMIN} + {1'b0, STEP})) begin
                            pwm_d   = PMIN;
                            state_d = SWEEP_UP;
                        end else begin
                            pwm_d = pwm_q - STEP;
                        end
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        // The done cycle still reads as busy/not-ready so the host sees one clean hand-back.
        ready_d = (state_d != RAMP) && !done_d;
        busy_d  = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            pwm_q   <= PMIN;
            tgt_q   <= 16'd0;
            step_q  <= 16'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign setPwm    = pwm_q;
    assign tgt_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with a 10-clock update tick.
// Expected trajectories are hand-computed from the clamp/step rules.
module tb_servo_ramp;
    localparam logic [15:0] PMIN = 16'h0600;
    localparam logic [15:0] PMAX = 16'h1A00;

    logic        clk = 1'b0;
    logic        resetb = 1'b1;
    logic        tgt_valid = 1'b0;
    logic        sweep = 1'b0;
    logic [15:0] tgt_data = 16'd0;
    logic [15:0] tgt_step = 16'd0;
    logic        tgt_ready;
    logic [15:0] setPwm;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt;

    servo_ramp #(
        .PMIN(PMIN), .PMAX(PMAX), .STEP(16'h0010), .TICKDIV(16'd9)
    ) dut (
        .clk(clk), .resetb(resetb),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_data(tgt_data), .tgt_step(tgt_step),
        .sweep(sweep), .setPwm(setPwm), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Edge k after reset release is a tick edge when k is a multiple of 10.
    always @(posedge clk or negedge resetb) begin
        if (!resetb) edge_cnt <= 0;
        else         edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic offer(input string tag, input logic [15:0] d, input logic [15:0] s);
        int w = 0;
        while (!tgt_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_rdy"}, {31'd0, tgt_ready}, 32'd1);
        tgt_data  = d;
        tgt_step  = s;
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        check({tag, "_acc"}, {29'd0, tgt_ready, busy, done}, 32'b010);
    endtask

    // Follows a ramp from just after its accept edge to the done pulse.
    task automatic track(input string tag, input logic [15:0] start, input logic [15:0] exp_final,
                         input int exp_moves, output int first_evt);
        logic [15:0] prev;
        int  moves = 0, cyc = 0, gap = 100, t_move = -1, t_done = -1;
        bit  range_ok = 1'b1, rate_ok = 1'b1, seen = 1'b0;
        prev = start;
        while (!seen && cyc < 3000) begin
            if (setPwm !== prev) begin
                moves++;
                if (gap < 10) rate_ok = 1'b0;
                gap  = 0;
                prev = setPwm;
                if (t_move < 0) t_move = cyc;
            end
            if (setPwm < PMIN || setPwm > PMAX) range_ok = 1'b0;
            if (done) begin
                seen   = 1'b1;
                t_done = cyc;
            end else begin
                @(negedge clk);
                cyc++;
                gap++;
            end
        end
        first_evt = (t_move >= 0) ? t_move : t_done;
        check({tag, "_done"}, {31'd0, seen}, 32'd1);
        check({tag, "_final"}, {16'd0, setPwm}, {16'd0, exp_final});
        check({tag, "_moves"}, moves, exp_moves);
        check({tag, "_range"}, {31'd0, range_ok}, 32'd1);
        check({tag, "_rate"}, {31'd0, rate_ok}, 32'd1);
        if (exp_moves > 0) check({tag, "_span"}, t_done - t_move, (exp_moves - 1) * 10);
        @(negedge clk);
        check({tag, "_end"}, {29'd0, done, busy, tgt_ready}, 32'b001);
    endtask

    task automatic ramp_to(input string tag, input logic [15:0] d, input logic [15:0] s,
                           input logic [15:0] exp_final, input int exp_moves);
        logic [15:0] start;
        int fe;
        start = setPwm;
        offer(tag, d, s);
        track(tag, start, exp_final, exp_moves, fe);
        check({tag, "_first"}, {31'd0, (fe >= 1 && fe <= 10)}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe;
        int w;
        #1 resetb = 1'b0;
        #2;
        check("rst_pwm", {16'd0, setPwm}, {16'd0, PMIN});
        check("rst_flags", {29'd0, tgt_ready, busy, done}, 32'b100);
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);

        ramp_to("normal",    16'h0640, 16'h0010, 16'h0640, 4);
        ramp_to("clamp_hi",  16'hFFFF, 16'h0800, 16'h1A00, 3);
        ramp_to("clamp_lo",  16'h0000, 16'h0800, 16'h0600, 3);
        ramp_to("step0",     16'h0603, 16'h0000, 16'h0603, 3);
        ramp_to("equal",     16'h0603, 16'h0005, 16'h0603, 0);
        ramp_to("below_min", 16'h0000, 16'h0100, 16'h0600, 1);

        // Valid held high: the second target lands one cycle after the done pulse.
        tgt_data  = 16'h0620;
        tgt_step  = 16'h0010;
        tgt_valid = 1'b1;
        @(negedge clk);
        check("hs_a_acc", {29'd0, tgt_ready, busy, done}, 32'b010);
        tgt_data = 16'h0700;
        tgt_step = 16'h0080;
        track("hs_a", 16'h0600, 16'h0620, 2, fe);
        @(negedge clk);
        tgt_valid = 1'b0;
        check("hs_b_acc", {29'd0, tgt_ready, busy, done}, 32'b010);
        check("hs_b_hold", {16'd0, setPwm}, 32'h0620);
        track("hs_b", 16'h0620, 16'h0700, 2, fe);

        // Accept exactly on a tick edge: that tick must not move the output.
        w = 0;
        while (((edge_cnt + 1) % 10) != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        offer("aligned", 16'h0710, 16'h0008);
        track("aligned", 16'h0700, 16'h0710, 2, fe);
        check("aligned_first", fe, 10);

        offer("midrst", 16'h1A00, 16'h0010);
        repeat (25) @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        #3 resetb = 1'b0;
        #1;
        check("midrst_pwm", {16'd0, setPwm}, {16'd0, PMIN});
        check("midrst_flags", {29'd0, tgt_ready, busy, done}, 32'b100);
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        check("post_rst", {13'd0, tgt_ready, busy, done, setPwm}, {13'd0, 3'b100, PMIN});

`ifdef SERVO_RAMP_SWEEP_EN
        begin
            logic [15:0] prev;
            int  ups = 0, downs = 0, cyc = 0;
            bit  step_ok = 1'b1;
            sweep = 1'b1;
            prev  = setPwm;
            while (setPwm !== PMAX && cyc < 5000) begin
                @(negedge clk);
                cyc++;
                if (setPwm !== prev) begin
                    if (setPwm - prev != 16'h0010) step_ok = 1'b0;
                    ups++;
                    prev = setPwm;
                end
            end
            check("sweep_up", ups, 320);
            check("sweep_busy", {31'd0, busy}, 32'd1);
            cyc = 0;
            while (setPwm !== PMIN && cyc < 5000) begin
                @(negedge clk);
                cyc++;
                if (setPwm !== prev) begin
                    if (prev - setPwm != 16'h0010) step_ok = 1'b0;
                    downs++;
                    prev = setPwm;
                end
            end
            check("sweep_dn", downs, 320);
            check("sweep_step", {31'd0, step_ok}, 32'd1);
            offer("sweep_tgt", 16'h0800, 16'h0100);
            sweep = 1'b0;
            track("sweep_tgt", 16'h0600, 16'h0800, 2, fe);
        end
`else
        begin
            bit static_ok = 1'b1;
            sweep = 1'b1;
            repeat (60) begin
                @(negedge clk);
                if (setPwm !== PMIN || busy !== 1'b0) static_ok = 1'b0;
            end
            sweep = 1'b0;
            check("sweep_off", {31'd0, static_ok}, 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
